// File: rtl/vend_sequencer.sv
// vend_sequencer: vending controller. Accumulates coin credit, arbitrates
// cancel/select/coin events, owns the nine-slot price and stock tables,
// drives the dispense handshake and pays change one greedy coin at a time.
module vend_sequencer #(
   parameter int MAX_CREDIT = 995,
   parameter int STOCK_INIT = 5
) (
   input  logic       clk,
   input  logic       rstN,
   input  logic       coinValid,
   input  logic [2:0] coinCode,
   input  logic       selValid,
   input  logic [3:0] selCode,
   input  logic       cancel,
   input  logic       cfgWe,
   input  logic [3:0] cfgAddr,
   input  logic [9:0] cfgPrice,
   input  logic [3:0] cfgStock,
   output logic       vendReq,
   output logic [3:0] vendSlot,
   input  logic       vendAck,
   output logic       payReq,
   output logic [2:0] payCoin,
   input  logic       payAck,
   output logic [9:0] credit,
   output logic [9:0] displayCents,
   output logic       coinReject,
   output logic [8:0] gLed,
   output logic [8:0] rLed,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CREDIT = 2'd1,
      VEND   = 2'd2,
      CHANGE = 2'd3
   } stateT;

   localparam logic [10:0] MaxCredit = 11'(MAX_CREDIT);
   localparam logic [3:0]  StockInit = 4'(STOCK_INIT);

   stateT       state;
   logic [9:0]  priceTab [0:8];
   logic [3:0]  stockTab [0:8];

   logic        selOk;
   logic [3:0]  selIdx;
   logic [9:0]  selPrice;
   logic        selBlocked;
   logic        cfgOk;
   logic [9:0]  coinVal;
   logic [10:0] coinSum;
   logic        coinOk;
   logic [9:0]  paidVal;
   logic [9:0]  payCredit;

   // Cent value of a denomination code; invalid codes are worth nothing.
   function automatic logic [9:0] coinValue(input logic [2:0] code);
      case (code)
         3'd0:    coinValue = 10'd5;
         3'd1:    coinValue = 10'd10;
         3'd2:    coinValue = 10'd25;
         3'd3:    coinValue = 10'd50;
         3'd4:    coinValue = 10'd100;
         3'd5:    coinValue = 10'd500;
         default: coinValue = 10'd0;
      endcase
   endfunction

   // Largest denomination not exceeding the amount still owed.
   function automatic logic [2:0] greedyCoin(input logic [9:0] amount);
      if (amount >= 10'd500) begin
         greedyCoin = 3'd5;
      end else if (amount >= 10'd100) begin
         greedyCoin = 3'd4;
      end else if (amount >= 10'd50) begin
         greedyCoin = 3'd3;
      end else if (amount >= 10'd25) begin
         greedyCoin = 3'd2;
      end else if (amount >= 10'd10) begin
         greedyCoin = 3'd1;
      end else begin
         greedyCoin = 3'd0;
      end
   endfunction

   // Event decode: selection lookup, coin acceptance and payout arithmetic.
   always_comb begin
      selOk      = (selCode <= 4'd8);
      selIdx     = selOk ? selCode : 4'd0;
      selPrice   = priceTab[selIdx];
      selBlocked = rLed[selIdx] | (credit < selPrice);
      cfgOk      = (cfgAddr <= 4'd8);
      coinVal    = coinValue(coinCode);
      coinSum    = {1'b0, credit} + {1'b0, coinVal};
      coinOk     = (coinVal != 10'd0) && (coinSum <= MaxCredit);
      paidVal    = coinValue(payCoin);
      if (payReq && payAck) begin
         // Saturate so an odd leftover can never wrap the credit register.
         payCredit = (paidVal >= credit) ? 10'd0 : (credit - paidVal);
      end else begin
         payCredit = credit;
      end
   end

   // Slot LEDs: red when the slot cannot sell at all, green when affordable now.
   always_comb begin
      gLed = 9'd0;
      rLed = 9'd0;
      for (int i = 0; i < 9; i++) begin
         rLed[i] = (stockTab[i] == 4'd0) || (priceTab[i] == 10'd0);
         gLed[i] = !rLed[i] && (credit >= priceTab[i]);
      end
   end

   // Sequencer FSM with registered outputs, credit and price/stock tables.
   always_ff @(posedge clk) begin
      if (!rstN) begin
         state        <= IDLE;
         credit       <= 10'd0;
         displayCents <= 10'd0;
         vendReq      <= 1'b0;
         vendSlot     <= 4'd0;
         payReq       <= 1'b0;
         payCoin      <= 3'd0;
         coinReject   <= 1'b0;
         busy         <= 1'b0;
         for (int i = 0; i < 9; i++) begin
            priceTab[i] <= 10'd0;
            stockTab[i] <= StockInit;
         end
      end else begin
         coinReject <= 1'b0;
         case (state)
            IDLE, CREDIT: begin
               if (cfgWe && (state == IDLE) && cfgOk) begin
                  priceTab[cfgAddr] <= cfgPrice;
                  stockTab[cfgAddr] <= cfgStock;
               end
               if (cancel) begin
                  if (state == CREDIT) begin
                     state        <= CHANGE;
                     busy         <= 1'b1;
                     displayCents <= credit;
                  end
               end else if (selValid) begin
                  if (selOk) begin
                     if ((state == IDLE) || selBlocked) begin
                        displayCents <= selPrice;
                     end else begin
                        credit           <= credit - selPrice;
                        displayCents     <= credit - selPrice;
                        stockTab[selIdx] <= stockTab[selIdx] - 4'd1;
                        vendSlot         <= selIdx;
                        vendReq          <= 1'b1;
                        busy             <= 1'b1;
                        state            <= VEND;
                     end
                  end
               end else if (coinValid) begin
                  if (coinOk) begin
                     credit       <= coinSum[9:0];
                     displayCents <= coinSum[9:0];
                     state        <= CREDIT;
                  end else begin
                     coinReject <= 1'b1;
                  end
               end
               // A coin that lost arbitration to cancel/select is refused.
               if (coinValid && (cancel || selValid)) begin
                  coinReject <= 1'b1;
               end
            end
            VEND: begin
               coinReject <= coinValid;
               if (vendAck) begin
                  vendReq <= 1'b0;
                  if (credit != 10'd0) begin
                     state <= CHANGE;
                  end else begin
                     state        <= IDLE;
                     busy         <= 1'b0;
                     displayCents <= 10'd0;
                  end
               end
            end
            CHANGE: begin
               coinReject <= coinValid;
               credit     <= payCredit;
               if (payCredit == 10'd0) begin
                  state        <= IDLE;
                  busy         <= 1'b0;
                  payReq       <= 1'b0;
                  displayCents <= 10'd0;
               end else begin
                  payReq       <= 1'b1;
                  payCoin      <= greedyCoin(payCredit);
                  displayCents <= payCredit;
               end
            end
            default: begin
               state   <= IDLE;
               busy    <= 1'b0;
               vendReq <= 1'b0;
               payReq  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vend_sequencer.sv
// tb_vend_sequencer: directed stimulus against a transaction-level model of
// the vending controller (credit, tables, payout coin queue).
module tb_vend_sequencer;

   localparam int MAXC  = 500;
   localparam int SINIT = 5;

   logic       clk = 1'b0;
   logic       rstN = 1'b0;
   logic       coinValid = 1'b0;
   logic [2:0] coinCode = 3'd0;
   logic       selValid = 1'b0;
   logic [3:0] selCode = 4'd0;
   logic       cancel = 1'b0;
   logic       cfgWe = 1'b0;
   logic [3:0] cfgAddr = 4'd0;
   logic [9:0] cfgPrice = 10'd0;
   logic [3:0] cfgStock = 4'd0;
   logic       vendAck = 1'b0;
   logic       payAck = 1'b0;
   logic       vendReq;
   logic [3:0] vendSlot;
   logic       payReq;
   logic [2:0] payCoin;
   logic [9:0] credit;
   logic [9:0] displayCents;
   logic       coinReject;
   logic [8:0] gLed;
   logic [8:0] rLed;
   logic       busy;

   vend_sequencer #(.MAX_CREDIT(MAXC), .STOCK_INIT(SINIT)) dut (
      .clk(clk), .rstN(rstN), .coinValid(coinValid), .coinCode(coinCode),
      .selValid(selValid), .selCode(selCode), .cancel(cancel),
      .cfgWe(cfgWe), .cfgAddr(cfgAddr), .cfgPrice(cfgPrice), .cfgStock(cfgStock),
      .vendReq(vendReq), .vendSlot(vendSlot), .vendAck(vendAck),
      .payReq(payReq), .payCoin(payCoin), .payAck(payAck),
      .credit(credit), .displayCents(displayCents), .coinReject(coinReject),
      .gLed(gLed), .rLed(rLed), .busy(busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit chkEn = 1'b0;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   int mMode;      // 0 idle, 1 holding credit, 2 dispensing, 3 paying change
   int mCredit, mDisp, mSlot;
   int mPrice [9];
   int mStock [9];
   bit mRej, mArmed;
   int payQ [$];   // change still owed, as denomination codes

   function automatic int valOf(input int code);
      case (code)
         0: return 5;
         1: return 10;
         2: return 25;
         3: return 50;
         4: return 100;
         5: return 500;
         default: return 0;
      endcase
   endfunction

   function automatic void enterChange();
      int rem;
      rem = mCredit;
      payQ.delete();
      for (int c = 5; c >= 0; c--) begin
         while (rem >= valOf(c)) begin
            payQ.push_back(c);
            rem -= valOf(c);
         end
      end
      mArmed = 1'b0;
   endfunction

   always @(posedge clk) begin : model
      int m0, s, v;
      if (!rstN) begin
         mMode = 0; mCredit = 0; mDisp = 0; mSlot = 0; mRej = 1'b0; mArmed = 1'b0;
         payQ.delete();
         for (int i = 0; i < 9; i++) begin
            mPrice[i] = 0;
            mStock[i] = SINIT;
         end
      end else begin
         m0 = mMode;
         mRej = 1'b0;
         if (m0 <= 1) begin
            if (cancel) begin
               if (m0 == 1) begin
                  mMode = 3; mDisp = mCredit; enterChange();
               end
            end else if (selValid) begin
               if (selCode < 9) begin
                  s = selCode;
                  if (m0 == 1 && mStock[s] > 0 && mPrice[s] > 0 && mCredit >= mPrice[s]) begin
                     mCredit -= mPrice[s]; mStock[s]--; mDisp = mCredit; mSlot = s; mMode = 2;
                  end else begin
                     mDisp = mPrice[s];
                  end
               end
            end else if (coinValid) begin
               v = valOf(coinCode);
               if (v > 0 && mCredit + v <= MAXC) begin
                  mCredit += v; mDisp = mCredit; mMode = 1;
               end else begin
                  mRej = 1'b1;
               end
            end
            if (coinValid && (cancel || selValid)) mRej = 1'b1;
            if (cfgWe && m0 == 0 && cfgAddr < 9) begin
               mPrice[cfgAddr] = cfgPrice;
               mStock[cfgAddr] = cfgStock;
            end
         end else if (m0 == 2) begin
            mRej = coinValid;
            if (vendAck) begin
               if (mCredit > 0) begin
                  mMode = 3; enterChange();
               end else begin
                  mMode = 0; mDisp = 0;
               end
            end
         end else begin
            mRej = coinValid;
            if (mArmed && payAck && payQ.size() > 0) begin
               mCredit -= valOf(payQ.pop_front());
               mDisp = mCredit;
            end
            mArmed = 1'b1;
            if (payQ.size() == 0) begin
               mMode = 0; mDisp = 0; mArmed = 1'b0;
            end
         end
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin : compare
      logic [8:0] eG, eR;
      bit expPay;
      if (chkEn) begin
         for (int i = 0; i < 9; i++) begin
            eR[i] = (mStock[i] == 0) || (mPrice[i] == 0);
            eG[i] = !eR[i] && (mCredit >= mPrice[i]);
         end
         expPay = (mMode == 3) && mArmed;
         chk("credit", credit, mCredit);
         chk("displayCents", displayCents, mDisp);
         chk("vendReq", vendReq, (mMode == 2) ? 1 : 0);
         chk("vendSlot", vendSlot, mSlot);
         chk("payReq", payReq, expPay ? 1 : 0);
         if (expPay && payQ.size() > 0) chk("payCoin", payCoin, payQ[0]);
         chk("coinReject", coinReject, mRej ? 1 : 0);
         chk("busy", busy, (mMode >= 2) ? 1 : 0);
         chk("gLed", gLed, eG);
         chk("rLed", rLed, eR);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic cfg(input int a, input int p, input int s);
      cfgWe = 1'b1; cfgAddr = 4'(a); cfgPrice = 10'(p); cfgStock = 4'(s);
      cyc();
      cfgWe = 1'b0;
   endtask

   task automatic coin(input int c);
      coinValid = 1'b1; coinCode = 3'(c);
      cyc();
      coinValid = 1'b0;
   endtask

   task automatic sel(input int c);
      selValid = 1'b1; selCode = 4'(c);
      cyc();
      selValid = 1'b0;
   endtask

   task automatic doCancel();
      cancel = 1'b1;
      cyc();
      cancel = 1'b0;
   endtask

   task automatic ack();
      vendAck = 1'b1;
      cyc();
      vendAck = 1'b0;
   endtask

   task automatic pay1();
      payAck = 1'b1;
      cyc();
      payAck = 1'b0;
   endtask

   initial begin
      repeat (3) cyc();
      chkEn = 1'b1;
      chk("rst credit", credit, 0);
      chk("rst rLed", rLed, 9'h1FF);
      chk("rst gLed", gLed, 0);
      chk("rst busy", busy, 0);
      rstN = 1'b1;

      // Exact-price purchase of A1, no change owed.
      cfg(0, 65, 1);
      coin(2); coin(2); coin(1); coin(0);
      chk("t1 credit", credit, 65);
      chk("t1 gLed0", gLed[0], 1);
      sel(0);
      chk("t1 vendReq", vendReq, 1);
      chk("t1 vendSlot", vendSlot, 0);
      ack();
      chk("t1 vendReq off", vendReq, 0);
      chk("t1 busy", busy, 0);
      chk("t1 rLed0", rLed[0], 1);
      repeat (3) cyc();
      chk("t1 payReq", payReq, 0);

      // Dollar for B2 at 40: change 50 then 10.
      cfg(4, 40, 5);
      coin(4);
      sel(4);
      chk("t2 credit", credit, 60);
      ack();
      chk("t2 payReq early", payReq, 0);
      cyc();
      chk("t2 payReq", payReq, 1);
      chk("t2 coin50", payCoin, 3);
      pay1();
      chk("t2 credit10", credit, 10);
      chk("t2 coin10", payCoin, 1);
      pay1();
      chk("t2 credit0", credit, 0);
      chk("t2 display0", displayCents, 0);
      chk("t2 busy", busy, 0);

      // Credit ceiling: five accepted at the limit, dollar refused.
      coin(5);
      chk("t3 credit500", credit, 500);
      coin(4);
      chk("t3 reject", coinReject, 1);
      chk("t3 credit held", credit, 500);
      cyc();
      chk("t3 reject pulse", coinReject, 0);
      doCancel();
      cyc();
      chk("t3 coin five", payCoin, 5);
      pay1();
      chk("t3 idle", busy, 0);
      chk("t3 credit0", credit, 0);

      // Unaffordable select, then cancel+select+coin in one cycle.
      cfg(8, 75, 3);
      coin(2); coin(0);
      sel(8);
      chk("t4 display75", displayCents, 75);
      chk("t4 credit30", credit, 30);
      chk("t4 not busy", busy, 0);
      cancel = 1'b1; selValid = 1'b1; selCode = 4'd8; coinValid = 1'b1; coinCode = 3'd0;
      cyc();
      cancel = 1'b0; selValid = 1'b0; coinValid = 1'b0;
      chk("t4 reject", coinReject, 1);
      chk("t4 busy", busy, 1);
      cyc();
      chk("t4 coin25", payCoin, 2);
      payAck = 1'b1;
      cyc();
      chk("t4 credit5", credit, 5);
      cyc();
      payAck = 1'b0;
      chk("t4 credit0", credit, 0);
      chk("t4 idle", busy, 0);

      // Everything ignored while dispensing; vendAck held off 20 cycles.
      coin(4);
      sel(4);
      coinValid = 1'b1; coinCode = 3'd0; selValid = 1'b1; selCode = 4'd8; cancel = 1'b1;
      cfgWe = 1'b1; cfgAddr = 4'd4; cfgPrice = 10'd40; cfgStock = 4'd0;
      cyc();
      coinValid = 1'b0; selValid = 1'b0; cancel = 1'b0; cfgWe = 1'b0;
      chk("t5 reject", coinReject, 1);
      repeat (20) cyc();
      chk("t5 vendReq held", vendReq, 1);
      chk("t5 vendSlot", vendSlot, 4);
      chk("t5 cfg ignored", rLed[4], 0);
      ack();
      cyc();
      payAck = 1'b1;
      cyc(); cyc();
      payAck = 1'b0;
      chk("t5 idle", busy, 0);

      // Reset in the middle of paying 85.
      coin(3); coin(2); coin(1);
      chk("t6 credit85", credit, 85);
      doCancel();
      cyc();
      chk("t6 paying", payReq, 1);
      rstN = 1'b0;
      cyc();
      rstN = 1'b1;
      chk("t6 credit", credit, 0);
      chk("t6 payReq", payReq, 0);
      chk("t6 busy", busy, 0);
      chk("t6 rLed", rLed, 9'h1FF);

      // Invalid coin and invalid selection codes.
      coin(6);
      chk("t7 bad coin", coinReject, 1);
      chk("t7 credit", credit, 0);
      coin(0);
      sel(12);
      chk("t7 bad sel", displayCents, 5);
      doCancel();
      cyc();
      pay1();
      chk("t7 idle", busy, 0);
      repeat (3) cyc();

      chkEn = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vend_sequencer.md
# vend_sequencer

Clocked controller that sequences the vending datapath: accumulates inserted coins into a credit register, arbitrates selection, cancel and coin events, owns the nine-slot price/stock tables, drives the dispense handshake and pays change coin-by-coin. Sits between the coin/keypad front end and the dispenser/payout mechanics. Credit, price and slot-LED outputs feed the 7-segment and LED display logic.

## Interface
- MAX_CREDIT, 995, maximum credit in cents (≤1023); a coin that would exceed it is rejected
- STOCK_INIT, 5, per-slot stock count after reset (≤15)
- clk  in  1  system clock
- rstN  in  1  synchronous reset, active-low; one clock, synchronous active-low reset
- coinValid  in  1  one-cycle coin-inserted strobe
- coinCode  in  3  0 nickel(5), 1 dime(10), 2 quarter(25), 3 fifty(50), 4 dollar(100), 5 five(500); 6–7 invalid
- selValid  in  1  one-cycle item-select strobe
- selCode  in  4  slot 0–8 = A1,A2,A3,B1,B2,B3,C1,C2,C3; 9–15 invalid
- cancel  in  1  one-cycle cancel strobe
- cfgWe  in  1  table write strobe
- cfgAddr  in  4  slot 0–8
- cfgPrice  in  10  price in cents
- cfgStock  in  4  stock count
- vendReq  out  1  dispense request
- vendSlot  out  4  slot being dispensed
- vendAck  in  1  dispenser done
- payReq  out  1  payout request
- payCoin  out  3  denomination code to pay (codes as coinCode)
- payAck  in  1  payout coin ejected
- credit  out  10  current credit, cents
- displayCents  out  10  value for the 7-segment display
- coinReject  out  1  one-cycle pulse: coin refused
- gLed  out  9  slot affordable: stock>0, price>0, credit≥price
- rLed  out  9  slot unavailable: stock==0 or price==0
- busy  out  1  high in VEND and CHANGE

## Operation
- States: IDLE (credit==0), CREDIT, VEND, CHANGE.
- Reset: state IDLE; credit, displayCents, all prices = 0; stock = STOCK_INIT; vendReq, payReq, coinReject, busy = 0; vendSlot, payCoin = 0; rLed = 9'h1FF, gLed = 0.
- One event per cycle, priority cancel > sel > coin. A coinValid dropped by priority pulses coinReject.
- Coin (IDLE/CREDIT): if the code is valid and credit+value ≤ MAX_CREDIT, credit += value, displayCents <= new credit, go to CREDIT. Otherwise coinReject pulses and credit is unchanged.
- Coins in VEND/CHANGE are rejected with coinReject.
- Select in IDLE: displayCents <= price[sel]; no state change. An invalid selCode is ignored.
- Select in CREDIT:
  - If rLed[sel] is set or credit < price: displayCents <= price[sel] and the state is held.
  - Otherwise: credit -= price, stock[sel] -= 1, displayCents <= remaining credit, vendSlot <= sel, vendReq <= 1, go to VEND.
- Cancel in CREDIT goes to CHANGE. Cancel is ignored in IDLE, VEND and CHANGE.
- VEND: vendReq and vendSlot are held until vendAck is sampled high. vendReq drops the next cycle. Then go to CHANGE if credit > 0, else IDLE. Selections are ignored in VEND.
- CHANGE: payCoin is the largest denomination ≤ credit (greedy); payReq is high.
  - On payAck, credit -= value of payCoin; payCoin and displayCents update the next cycle.
  - When credit reaches 0, payReq drops and the state goes to IDLE.
- Entry to IDLE clears displayCents to 0.
- cfgWe is accepted in IDLE only and is ignored elsewhere. An invalid cfgAddr is ignored.
- gLed and rLed are combinational from the tables and credit.

## Timing
- All state, credit, table and output registers update on the rising edge of clk. The only combinational outputs are gLed and rLed.
- Coin accept: credit is visible 1 cycle after the coinValid edge.
- Select to vendReq: 1 cycle.
- vendAck sampled at edge N: vendReq is low and the state is CHANGE/IDLE at N+1. payReq is first high at N+2 at the earliest.
- payAck at edge N: credit is decremented at N+1. payReq stays high across consecutive coins. payAck may be held high and then pays one coin per cycle.
- A cfgWe write is visible in gLed/rLed 1 cycle later.
- rstN low at any edge aborts VEND/CHANGE immediately; the in-flight credit is lost and the state returns to IDLE.
- Credit never underflows or exceeds MAX_CREDIT.

## Test plan
- Cfg slot A1 price 65, stock 1. Insert quarter, quarter, dime, nickel → credit 65, gLed[0]=1. Select A1 → vendReq with vendSlot=0 next cycle. vendAck → IDLE, rLed[0]=1, no payReq.
- Price B2=40, insert dollar, select B2, vendAck → CHANGE pays codes 3(50) then 1(10) → credit 0, IDLE, displayCents 0.
- Insert five, then a dollar with MAX_CREDIT=500 → coinReject pulse, credit stays 500. Cancel → payCoin=5, one payAck → IDLE.
- Credit 30, select C3 priced 75 → displayCents=75, state CREDIT, credit 30. Same-cycle cancel+selValid+coinValid → CHANGE, coinReject pulse.
- In VEND, assert coinValid (rejected), selValid and cancel (ignored), and cfgWe (ignored). Hold vendAck low 20 cycles → vendReq held and vendSlot stable.
- Pull rstN low mid-CHANGE with credit 85 → next cycle IDLE, credit 0, payReq 0, prices 0, stock=STOCK_INIT.
